// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
//
// Receive controller for the UART RX path. Works together with an external
// edge/bit counter: this block drives cnt_enable and the counter returns
// edge_cnt (oversampling tick within the current bit) and bit_cnt (bit index
// within the frame, start bit = 0).
//
// For each bit, the middle three oversampling ticks are captured and
// majority-voted. The start bit is validated. Data is deserialized LSB-first.
// Optional parity and the stop bit are checked. A clean frame updates p_data
// together with a one-cycle data_valid pulse.
//
// Ports
//   clk          in   1           clock
//   rst_n        in   1           asynchronous active-low reset
//   rx_in        in   1           serial line (already synchronized), idle high
//   prescale     in   6           oversampling ratio: 8, 16 or 32
//   par_en       in   1           frame carries a parity bit
//   par_typ      in   1           0: even parity, 1: odd parity
//   edge_cnt     in   6           counter: tick 0..prescale-1 within bit
//   bit_cnt      in   4           counter: bit index in frame
//   cnt_enable   out  1           counter run enable; 0 clears the counter
//   p_data       out  DATA_WIDTH  last good byte
//   data_valid   out  1           one-cycle pulse on a clean frame
//   par_err      out  1           parity mismatch in last frame (held)
//   stp_err      out  1           stop bit sampled low in last frame (held)
//   start_glitch out  1           one-cycle pulse: false start rejected
//
// DATA_WIDTH supports 5..8 data bits per frame.
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_in,
    input  logic [5:0]            prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [5:0]            edge_cnt,
    input  logic [3:0]            bit_cnt,
    output logic                  cnt_enable,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  start_glitch
);

    // FSM encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // bit_cnt value carried by the final data bit (start bit is index 0)
    localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH);

    logic [2:0]            state_reg;
    logic [2:0]            state_next;

    logic [2:0]            samp_reg;      // s0, s1, s2 of the current bit
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  parity_reg;    // running XOR of received data bits
    logic [DATA_WIDTH-1:0] p_data_reg;
    logic                  data_valid_reg;
    logic                  par_err_reg;
    logic                  stp_err_reg;
    logic                  start_glitch_reg;

    logic [5:0]            half;
    logic [5:0]            last_edge;
    logic                  at_last;
    logic [2:0]            sample_hit;
    logic                  smp;
    logic                  busy;
    logic                  idle_start;

    // -----------------------------------------------------------------------
    // Bit timing helpers
    // -----------------------------------------------------------------------
    // Sample points sit on ticks h-1, h, h+1 around the bit centre. For every
    // legal prescale, h+1 < prescale-1, so all three samples are taken before
    // the last tick, where the voted value is consumed.
    assign half      = {1'b0, prescale[5:1]};
    assign last_edge = prescale - 6'd1;
    assign at_last   = (edge_cnt == last_edge);
    assign busy      = (state_reg != ST_IDLE);

    // A low line while idle begins a frame. The same condition clears the
    // per-frame flags and accumulators on the way into START.
    assign idle_start = (state_reg == ST_IDLE) && !rx_in;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sample_pt
            localparam logic [5:0] OFFSET = 6'(gi);
            assign sample_hit[gi] = busy && (edge_cnt == half + OFFSET - 6'd1);
        end
    endgenerate

    // 2-of-3 majority vote. A single-tick glitch on any one sample is rejected.
    assign smp = (samp_reg[0] & samp_reg[1]) |
                 (samp_reg[0] & samp_reg[2]) |
                 (samp_reg[1] & samp_reg[2]);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!rx_in) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (at_last) begin
                    state_next = smp ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (at_last && (bit_cnt == LAST_DATA_BIT)) begin
                    state_next = par_en ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (at_last) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (at_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Oversample capture
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_reg <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sample_hit[i]) begin
                    samp_reg[i] <= rx_in;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Deserializer and running parity
    // -----------------------------------------------------------------------
    // Right shift with the new bit entering at the MSB. After DATA_WIDTH bits,
    // the first (LSB-first) bit received lands in bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg  <= '0;
            parity_reg <= 1'b0;
        end else if (idle_start) begin
            shift_reg  <= '0;
            parity_reg <= 1'b0;
        end else if ((state_reg == ST_DATA) && at_last) begin
            shift_reg  <= {smp, shift_reg[DATA_WIDTH-1:1]};
            parity_reg <= parity_reg ^ smp;
        end
    end

    // -----------------------------------------------------------------------
    // Frame checks and result outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_data_reg       <= '0;
            data_valid_reg   <= 1'b0;
            par_err_reg      <= 1'b0;
            stp_err_reg      <= 1'b0;
            start_glitch_reg <= 1'b0;
        end else begin
            // Both pulses last exactly one cycle.
            data_valid_reg   <= 1'b0;
            start_glitch_reg <= 1'b0;

            // Error flags hold across IDLE and clear only when a new frame
            // starts. p_data is left untouched by errored frames.
            if (idle_start) begin
                par_err_reg <= 1'b0;
                stp_err_reg <= 1'b0;
            end

            if (at_last) begin
                case (state_reg)
                    ST_START: begin
                        // A start bit that votes high was noise on an idle line.
                        if (smp) begin
                            start_glitch_reg <= 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        // Expected parity bit is XOR(data) for even, its
                        // complement for odd.
                        par_err_reg <= (smp != (parity_reg ^ par_typ));
                    end
                    ST_STOP: begin
                        stp_err_reg <= ~smp;
                        // par_err_reg is always cleared at frame start, so
                        // it is 0 here for frames without parity.
                        if (!par_err_reg && smp) begin
                            p_data_reg     <= shift_reg;
                            data_valid_reg <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Moore output, so cnt_enable drops as soon as reset forces IDLE.
    assign cnt_enable   = busy;
    assign p_data       = p_data_reg;
    assign data_valid   = data_valid_reg;
    assign par_err      = par_err_reg;
    assign stp_err      = stp_err_reg;
    assign start_glitch = start_glitch_reg;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
//
// Directed bench for uart_rx_ctrl. It includes a model of the RX edge/bit
// counter so the controller runs closed-loop. A line driver serializes
// frames, and a negedge monitor counts output pulses.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_in = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       par_en = 1'b1;
    logic       par_typ = 1'b0;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       cnt_enable;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       start_glitch;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int dv_count = 0;
    int dv_cyc = 0;
    int glitch_count = 0;

    uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_in        (rx_in),
        .prescale     (prescale),
        .par_en       (par_en),
        .par_typ      (par_typ),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt),
        .cnt_enable   (cnt_enable),
        .p_data       (p_data),
        .data_valid   (data_valid),
        .par_err      (par_err),
        .stp_err      (stp_err),
        .start_glitch (start_glitch)
    );

    always #5 clk = ~clk;

    // Edge/bit counter model: cleared while disabled, and wraps edge_cnt at
    // prescale-1 while advancing bit_cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= 6'd0;
            bit_cnt  <= 4'd0;
        end else if (!cnt_enable) begin
            edge_cnt <= 6'd0;
            bit_cnt  <= 4'd0;
        end else if (edge_cnt == prescale - 6'd1) begin
            edge_cnt <= 6'd0;
            bit_cnt  <= bit_cnt + 4'd1;
        end else begin
            edge_cnt <= edge_cnt + 6'd1;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            dv_count = dv_count + 1;
            dv_cyc   = cyc;
        end
        if (start_glitch) begin
            glitch_count = glitch_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one bit for prescale cycles. When glitch_bit >= 0, invert the line
    // for the single cycle in which the counter shows tick h of that data bit.
    task automatic send_bit(input logic b, input int glitch_bit);
        for (int c = 0; c < int'(prescale); c++) begin
            if (glitch_bit >= 0 && cnt_enable && bit_cnt == 4'(glitch_bit + 1) &&
                edge_cnt == (prescale >> 1)) begin
                rx_in = ~b;
            end else begin
                rx_in = b;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_body(input logic [7:0] d, input logic with_par, input logic par_bit,
                             input logic stop_bit, input int glitch_bit);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i], glitch_bit);
        end
        if (with_par) begin
            send_bit(par_bit, glitch_bit);
        end
        send_bit(stop_bit, glitch_bit);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic with_par, input logic par_bit,
                              input logic stop_bit, input int glitch_bit, output int start_cyc);
        start_cyc = cyc;
        send_bit(1'b0, glitch_bit);
        send_body(d, with_par, par_bit, stop_bit, glitch_bit);
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int st;
        int dv0;
        int g0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cnt_enable", cnt_enable, 0);
        check("rst_p_data", p_data, 0);
        check("rst_flags", {par_err, stp_err}, 0);
        check("rst_pulses", {data_valid, start_glitch}, 0);
        rst_n = 1'b1;
        idle(4);

        // 1: 0xA5, even parity bit 0, good stop
        dv0 = dv_count;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, -1, st);
        idle(32);
        $display("frame 0xA5 even-parity: p_data=%0h dv=%0d", p_data, dv_count - dv0);
        check("c1_dv_count", dv_count - dv0, 1);
        check("c1_p_data", p_data, 8'hA5);
        check("c1_par_err", par_err, 0);
        check("c1_stp_err", stp_err, 0);
        check("c1_latency", dv_cyc - st, 89);

        // 2: false start, low for 2 clks
        dv0 = dv_count;
        g0  = glitch_count;
        rx_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle(20);
        $display("false start: glitch=%0d dv=%0d", glitch_count - g0, dv_count - dv0);
        check("c2_glitch", glitch_count - g0, 1);
        check("c2_no_dv", dv_count - dv0, 0);
        check("c2_p_data", p_data, 8'hA5);
        check("c2_idle", cnt_enable, 0);

        // 3: parity error, then good 0x5A
        dv0 = dv_count;
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1, -1, st);
        idle(32);
        $display("frame 0xA5 bad parity: par_err=%0b dv=%0d", par_err, dv_count - dv0);
        check("c3_par_err", par_err, 1);
        check("c3_no_dv", dv_count - dv0, 0);
        check("c3_p_data_kept", p_data, 8'hA5);
        dv0 = dv_count;
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1, -1, st);
        idle(32);
        $display("frame 0x5A: p_data=%0h par_err=%0b", p_data, par_err);
        check("c3_par_err_clr", par_err, 0);
        check("c3_p_data", p_data, 8'h5A);
        check("c3_dv", dv_count - dv0, 1);

        // 4: stop error, then good frame with stp_err cleared at START entry
        dv0 = dv_count;
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0, -1, st);
        idle(32);
        $display("frame 0xFF bad stop: stp_err=%0b dv=%0d", stp_err, dv_count - dv0);
        check("c4_stp_err", stp_err, 1);
        check("c4_no_dv", dv_count - dv0, 0);
        check("c4_p_data_kept", p_data, 8'h5A);
        dv0 = dv_count;
        rx_in = 1'b0;
        @(posedge clk);
        #1;
        check("c4_stp_clr_at_start", stp_err, 0);
        check("c4_busy", cnt_enable, 1);
        repeat (int'(prescale) - 1) @(posedge clk);
        #1;
        send_body(8'h3C, 1'b1, 1'b0, 1'b1, -1);
        idle(32);
        $display("frame 0x3C: p_data=%0h stp_err=%0b", p_data, stp_err);
        check("c4_p_data", p_data, 8'h3C);
        check("c4_dv", dv_count - dv0, 1);

        // 5: glitch at tick h of data bit 3 (bit value 0 in 0x96)
        dv0 = dv_count;
        send_frame(8'h96, 1'b1, 1'b0, 1'b1, 3, st);
        idle(32);
        $display("frame 0x96 glitched: p_data=%0h errs=%0b%0b", p_data, par_err, stp_err);
        check("c5_p_data", p_data, 8'h96);
        check("c5_errs", {par_err, stp_err}, 0);
        check("c5_dv", dv_count - dv0, 1);

        // 6: prescale 16, no parity, back-to-back 0x3C frames
        prescale = 6'd16;
        par_en   = 1'b0;
        idle(4);
        dv0 = dv_count;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, -1, st);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, -1, st);
        idle(64);
        $display("back-to-back 0x3C x2 @16: p_data=%0h dv=%0d", p_data, dv_count - dv0);
        check("c6_dv_count", dv_count - dv0, 2);
        check("c6_p_data", p_data, 8'h3C);

        // 7: reset asserted at data bit 4, then a good frame
        prescale = 6'd8;
        par_en   = 1'b1;
        idle(4);
        send_bit(1'b0, -1);
        for (int i = 0; i < 4; i++) begin
            send_bit(i < 2, -1);   // bits 0..3 of 0xC3
        end
        rst_n = 1'b0;
        #1;
        $display("reset mid-frame: cnt_enable=%0b p_data=%0h", cnt_enable, p_data);
        check("c7_cnt_enable", cnt_enable, 0);
        check("c7_p_data", p_data, 0);
        check("c7_outs", {data_valid, par_err, stp_err, start_glitch}, 0);
        rx_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(8);
        dv0 = dv_count;
        send_frame(8'hC3, 1'b1, 1'b0, 1'b1, -1, st);
        idle(32);
        $display("frame 0xC3 after reset: p_data=%0h dv=%0d", p_data, dv_count - dv0);
        check("c7_p_data_after", p_data, 8'hC3);
        check("c7_dv", dv_count - dv0, 1);
        check("c7_errs", {par_err, stp_err}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
